l2_writeback_buffer: RTL

- Victim/writeback buffer directly downstream of the 4-way L2 cache.
- Captures each block the L2 evicts (its replacement pulse plus the evicted block) into a small FIFO and drains it to main memory over a req/ack handshake.
- Lets the L2 finish its replacement without stalling on memory latency.
- Provides a combinational lookup port so an L2 miss can be served from a block still waiting in the buffer.

---
 rtl/l2_writeback_buffer_if.sv | 28 ++
 rtl/l2_writeback_buffer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/l2_writeback_buffer_if.sv
// Bus bundle for the L2 writeback buffer: eviction push, memory drain handshake and miss lookup.
// "slave" is the buffer's view; "master" is the L2 / memory side that drives it.
interface l2_writeback_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
);
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ready;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [ADDR_W-1:0] lookup_addr;
  logic              lookup_hit;
  logic [DATA_W-1:0] lookup_data;

  modport slave (
    input  wb_valid, wb_addr, wb_data, mem_ack, lookup_addr,
    output wb_ready, mem_req, mem_addr, mem_wdata, lookup_hit, lookup_data
  );

  modport master (
    output wb_valid, wb_addr, wb_data, mem_ack, lookup_addr,
    input  wb_ready, mem_req, mem_addr, mem_wdata, lookup_hit, lookup_data
  );
endinterface

// File: rtl/l2_writeback_buffer.sv
// Victim FIFO behind the L2: buffers evicted blocks, drains them to memory, serves miss lookups.
// Optional macro WB_COALESCE_EN: a push hitting a queued (not in-flight) block overwrites it in place.
module l2_writeback_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  l2_writeback_buffer_if.slave     bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BA_W  = ADDR_W - 2;

  typedef enum logic {IDLE, SEND} state_t;

  logic [DEPTH-1:0]  valid_q;
  logic [BA_W-1:0]   addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  state_t            state_q, state_d;

  logic              full, wb_rdy, push, alloc, load, pop;
  logic [DATA_W-1:0] head_data;
  logic              lk_hit;
  logic [DATA_W-1:0] lk_data;
  logic [PTR_W-1:0]  lk_idx;
  logic              unused_addr_bits;

  assign full = (count_q == CNT_W'(DEPTH));
  assign push = bus.wb_valid && wb_rdy;
  assign unused_addr_bits = ^{bus.wb_addr[1:0], bus.lookup_addr[1:0]};

`ifdef WB_COALESCE_EN
  logic              co_hit;
  logic [PTR_W-1:0]  co_idx, sc_idx;

  // Scan oldest to youngest so the last match is the youngest; the in-flight head is untouchable.
  always_comb begin
    co_hit = 1'b0;
    co_idx = '0;
    sc_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      sc_idx = rd_ptr_q + PTR_W'(k);
      if (valid_q[sc_idx] && addr_q[sc_idx] == bus.wb_addr[ADDR_W-1:2] &&
          !(state_q == SEND && sc_idx == rd_ptr_q)) begin
        co_hit = 1'b1;
        co_idx = sc_idx;
      end
    end
  end

  assign wb_rdy = !full || co_hit;
  assign alloc  = push && !co_hit;

  // A coalescing write to the head while it is being loaded must reach memory.
  always_comb begin
    head_data = data_q[rd_ptr_q];
    if (push && co_hit && co_idx == rd_ptr_q) head_data = bus.wb_data;
  end
`else
  assign wb_rdy    = !full;
  assign alloc     = push;
  assign head_data = data_q[rd_ptr_q];
`endif

  always_comb begin
    lk_hit = 1'b0;
    lk_data = '0;
    lk_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      lk_idx = rd_ptr_q + PTR_W'(k);
      if (valid_q[lk_idx] && addr_q[lk_idx] == bus.lookup_addr[ADDR_W-1:2]) begin
        lk_hit = 1'b1;
        lk_data = data_q[lk_idx];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    load = 1'b0;
    pop = 1'b0;
    case (state_q)
      IDLE: if (count_q != '0) begin
        state_d = SEND;
        load = 1'b1;
      end
      SEND: if (bus.mem_ack) begin
        state_d = IDLE;
        pop = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage stage: block payload, no reset (entries are qualified by valid_q)
  always_ff @(posedge clk) begin
    if (alloc) begin
      addr_q[wr_ptr_q] <= bus.wb_addr[ADDR_W-1:2];
      data_q[wr_ptr_q] <= bus.wb_data;
    end
`ifdef WB_COALESCE_EN
    if (push && co_hit) data_q[co_idx] <= bus.wb_data;
`endif
  end

  // Control stage: pointers, occupancy, drain FSM and the registered memory request
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (bus.wb_valid && !wb_rdy) overflow_q <= 1'b1;
      if (alloc) begin
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CNT_W'(alloc) - CNT_W'(pop);
      if (load) begin
        mem_addr_q  <= {addr_q[rd_ptr_q], 2'b00};
        mem_wdata_q <= head_data;
      end
    end
  end

  assign bus.wb_ready    = wb_rdy;
  assign bus.mem_req     = (state_q == SEND);
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.lookup_hit  = lk_hit;
  assign bus.lookup_data = lk_data;
  assign count           = count_q;
  assign overflow        = overflow_q;

endmodule
